cur_blk_fetch: RTL
==================

CUR_BLK_FETCH -- requirements
Module: cur_blk_fetch

Interface
REQ-001 Parameters: PITCH, default 64, byte distance between vertically adjacent pixel rows in current-frame memory.
REQ-002 Parameters: BLK, default 16, block width/height in pixels; BLK/4 words per row, BLK/2 row pairs.
REQ-003 Parameters: ADDR_W, default 23, byte-address width.
REQ-004 Parameters: FRAME_BYTES, default 8294400, current-frame memory size in bytes.
REQ-005 Ports: clk  in  1  single clock, all state on rising edge.
REQ-006 Ports: rst  in  1  asynchronous, active-high reset.
REQ-007 Ports: start  in  1  one-cycle request to fetch one block.
REQ-008 Ports: base_addr  in  ADDR_W  byte address of block top-left pixel, sampled on accepted start.
REQ-009 Ports: busy  out  1  high from accepted start until done.
REQ-010 Ports: done  out  1  one-cycle pulse after last beat accepted.
REQ-011 Ports: err  out  1  one-cycle pulse when start is rejected as out of range.
REQ-012 Ports: mem_addr  out  ADDR_W  byte address of upper-row word.
REQ-013 Ports: mem_rd  out  1  read strobe, mem_data valid in same cycle (combinational memory).
REQ-014 Ports: mem_data1  in  32  bytes addr..addr+3, byte at addr in bits 31:24.
REQ-015 Ports: mem_data2  in  32  bytes addr+PITCH..addr+PITCH+3, same byte order.
REQ-016 Ports: pix_valid  out  1; pix_ready  in  1; pix_data  out  64 = {mem_data1, mem_data2} captured.
REQ-017 Ports: pix_col  out  2  word index in row; pix_rp  out  3  row-pair index of current beat.

Function
REQ-018 FSM states IDLE, FETCH, DRAIN; reset state IDLE.
REQ-019 IDLE: start high and range ok -> FETCH next cycle, busy=1; start with range fail -> err pulse, stay IDLE.
REQ-020 Range ok iff base_addr + (BLK-1)*PITCH + BLK-1 <= FRAME_BYTES-1, computed in ADDR_W+1 bits (no wrap).
REQ-021 start while busy is ignored, no err.
REQ-022 Read order: col 0..BLK/4-1 inner, row pair 0..BLK/2-1 outer; 32 reads for BLK=16.
REQ-023 mem_addr = base + 2*rp*PITCH + 4*col; updated incrementally (+4 per word, +2*PITCH-(BLK-4) at row-pair wrap), no multiplier.
REQ-024 Read issued (mem_rd=1) in FETCH iff !pix_valid or pix_ready; mem_rd=0 otherwise, mem_addr held.
REQ-025 Issued read captures pix_data, pix_col, pix_rp and sets pix_valid next cycle.
REQ-026 pix_valid holds with stable pix_data until pix_ready; valid&ready with no new read clears pix_valid.
REQ-027 Full throughput: ready held high -> one beat per cycle, first pix_valid 2 cycles after start.
REQ-028 Last read issued -> DRAIN; DRAIN exits when last beat accepted -> done pulse that same-edge, IDLE, busy=0.
REQ-029 Total latency, ready always high, BLK=16: start at cycle 0 -> done high in cycle 33.
REQ-030 New start accepted in the cycle done is high's following cycle (IDLE), never the same cycle.

Reset
REQ-031 rst high asynchronously forces IDLE; busy, done, err, mem_rd, pix_valid=0; mem_addr, pix_data, pix_col, pix_rp=0.
REQ-032 rst mid-block aborts; no done, partial beats discarded; fetch restarts only on new start.

Structure
REQ-033 Shared package me_pkg holds ADDR_W, FRAME_BYTES, PITCH, BLK defaults and FSM state encoding.
REQ-034 One sub-module natural: cur_blk_addr_gen (col/rp counters, mem_addr stepping, last flag).

Verification
REQ-035 Behavioural byte-array memory (mem[i] = i mod 256), base_addr=0, ready=1 -> 32 beats, beat 0 pix_data=0x00010203_40414243, done cycle 33.
REQ-036 base_addr=0x000100, ready toggling 1/0 -> beat order and data unchanged, pix_data stable while stalled, 32 beats exactly.
REQ-037 base_addr=FRAME_BYTES-16 -> err pulse, busy stays 0, no mem_rd.
REQ-038 start pulse at beat 10 of running block -> ignored, exactly 32 beats, single done.
REQ-039 rst asserted after beat 12 -> all outputs zero immediately, no done; subsequent start fetches full block from beat 0.
REQ-040 base_addr=FRAME_BYTES-(15*64+16) (last legal) -> accepted, final mem_addr = FRAME_BYTES-PITCH-4-... checked against model, no err.

Source files
------------

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation block fetchers.
// Holds the default geometry of the current-frame memory, the default block
// size, and the state encoding used by the block fetch controller.
package me_pkg;

    localparam int ADDR_W_DEFAULT      = 23;
    localparam int FRAME_BYTES_DEFAULT = 8294400;
    localparam int PITCH_DEFAULT       = 64;
    localparam int BLK_DEFAULT         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/cur_blk_addr_gen.sv
// Address generator for one current-frame block.
// Walks the block as words within a row (col) and pairs of rows (rp), with
// col as the inner index. The byte address is stepped incrementally:
// +4 for the next word and a fixed jump to the first word of the next row pair.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       restart the walk at base_addr (col = 0, rp = 0)
//   base_addr  byte address of the block's top-left pixel
//   step       advance to the next word; ignored on the last word
//   addr       byte address of the current upper-row word
//   col, rp    current word index and row-pair index
//   last       current word is the final one of the block
module cur_blk_addr_gen
    import me_pkg::*;
#(
    parameter int PITCH  = PITCH_DEFAULT,
    parameter int BLK    = BLK_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        col,
    output logic [2:0]        rp,
    output logic              last
);

    localparam logic [1:0]        COL_LAST  = 2'(BLK / 4 - 1);
    localparam logic [2:0]        RP_LAST   = 3'(BLK / 2 - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    // From the last word of a row pair back to column 0, two rows further down.
    localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(2 * PITCH - (BLK - 4));

    assign last = (col == COL_LAST) && (rp == RP_LAST);

    // Counters and address freeze on the last word so the final address stays
    // visible after the block completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            col  <= '0;
            rp   <= '0;
        end else if (load) begin
            addr <= base_addr;
            col  <= '0;
            rp   <= '0;
        end else if (step && !last) begin
            if (col == COL_LAST) begin
                col  <= '0;
                rp   <= rp + 3'd1;
                addr <= addr + WRAP_STEP;
            end else begin
                col  <= col + 2'd1;
                addr <= addr + WORD_STEP;
            end
        end
    end

endmodule

// File: rtl/cur_blk_fetch.sv
// Current-block fetcher: reads one BLK x BLK block from current-frame memory,
// two vertically adjacent rows per read, and streams it out as 64-bit beats
// over a valid/ready handshake.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   start, base_addr      one-cycle fetch request and block top-left address
//   busy, done, err       block in progress, completion pulse, rejection pulse
//   mem_addr, mem_rd      upper-row word address and read strobe
//   mem_data1, mem_data2  upper and lower row words (combinational memory)
//   pix_valid, pix_ready  output beat handshake
//   pix_data              {upper word, lower word} of the beat
//   pix_col, pix_rp       word index and row-pair index of the beat
module cur_blk_fetch
    import me_pkg::*;
#(
    parameter int PITCH       = PITCH_DEFAULT,
    parameter int BLK         = BLK_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_data1,
    input  logic [31:0]       mem_data2,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [63:0]       pix_data,
    output logic [1:0]        pix_col,
    output logic [2:0]        pix_rp
);

    localparam int            SPAN      = (BLK - 1) * PITCH + BLK - 1;
    localparam logic [ADDR_W:0] SPAN_EXT  = (ADDR_W + 1)'(SPAN);
    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W + 1)'(FRAME_BYTES - 1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W:0]   block_end;
    logic              range_ok;
    logic              accept;
    logic              rd;
    logic              gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [1:0]        gen_col;
    logic [2:0]        gen_rp;

    // The bottom-right byte of the block is computed one bit wider than the
    // address so a base near the top of the address space cannot wrap into range.
    assign block_end = {1'b0, base_addr} + SPAN_EXT;
    assign range_ok  = (block_end <= LAST_BYTE);
    assign accept    = (state == ST_IDLE) && start && range_ok;

    // A read may only be issued when the output register is free or being
    // emptied this cycle, so no beat is ever overwritten.
    assign rd        = (state == ST_FETCH) && (!pix_valid || pix_ready);

    assign mem_rd    = rd;
    assign mem_addr  = gen_addr;

    cur_blk_addr_gen #(
        .PITCH  (PITCH),
        .BLK    (BLK),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .base_addr (base_addr),
        .step      (rd),
        .addr      (gen_addr),
        .col       (gen_col),
        .rp        (gen_rp),
        .last      (gen_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs. done is raised in the same cycle the final
    // beat is handshaken, so the controller is back in IDLE on the next cycle.
    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (range_ok) begin
                        state_next = ST_FETCH;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (rd && gen_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pix_valid && pix_ready) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output beat register: loaded by every issued read, held while stalled,
    // emptied when a beat is taken and nothing replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_col   <= '0;
            pix_rp    <= '0;
        end else if (rd) begin
            pix_valid <= 1'b1;
            pix_data  <= {mem_data1, mem_data2};
            pix_col   <= gen_col;
            pix_rp    <= gen_rp;
        end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

endmodule
